// File: rtl/pp_row_scheduler.sv
// Frame/row sequencer for the preprocess output FIFO feeding the Gaussian stage.
// Flushes the FIFO at frame start, issues one row-long read burst whenever a full
// row is buffered and downstream is ready, and tags returned pixels with
// line/frame markers. Frames cut short by an early frame start are aborted.
module pp_row_scheduler #(
    parameter int unsigned ROW_WIDTH    = 640,
    parameter int unsigned NUM_ROWS     = 480,
    parameter int unsigned FILL_W       = 11,
    parameter int unsigned FLUSH_CYCLES = 4,
    localparam int unsigned ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_enable,
    input  logic              i_frame_start,
    input  logic [FILL_W-1:0] i_fill,
    input  logic              i_ds_ready,
    output logic              o_flush,
    output logic              o_rd,
    output logic              o_valid,
    output logic              o_sol,
    output logic              o_eol,
    output logic              o_sof,
    output logic              o_eof,
    output logic [ROW_W-1:0]  o_row,
    output logic              o_busy,
    output logic              o_frame_err
);

    localparam int unsigned COL_W  = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam int unsigned FCNT_W = 4;

    localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(ROW_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(NUM_ROWS - 1);
    localparam logic [FCNT_W-1:0] LAST_FLUSH = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [FILL_W-1:0] ROW_FILL   = FILL_W'(ROW_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_WAIT  = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic               abort;
    logic               last_col;
    logic               last_row;
    logic               flush_d;
    logic               rd_d;
    logic               valid_d;
    logic               sol_d;
    logic               eol_d;
    logic               sof_d;
    logic               eof_d;

    assign last_col = (col_q == LAST_COL);
    assign last_row = (o_row == LAST_ROW);

    // Busy is a pure decode of the state register.
    assign o_busy = (state_q != S_IDLE);

    // Next-state, counter and output-pipeline decisions.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = o_row;
        fcnt_d  = fcnt_q;
        abort   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_enable && i_frame_start) begin
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                    row_d   = '0;
                end
            end
            S_FLUSH: begin
                row_d = '0;
                if (i_frame_start) begin
                    fcnt_d = '0;
                end else if (fcnt_q == LAST_FLUSH) begin
                    state_d = S_WAIT;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (i_frame_start) begin
                    abort   = 1'b1;
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                    row_d   = '0;
                end else if (!i_enable) begin
                    state_d = S_IDLE;
                end else if ((i_fill >= ROW_FILL) && i_ds_ready) begin
                    state_d = S_BURST;
                    col_d   = '0;
                end
            end
            S_BURST: begin
                // A frame start on the very last read of the frame is not an abort.
                if (i_frame_start && !(last_col && last_row)) begin
                    abort   = 1'b1;
                    state_d = S_FLUSH;
                    fcnt_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else if (last_col) begin
                    col_d = '0;
                    if (i_frame_start) begin
                        state_d = S_FLUSH;
                        fcnt_d  = '0;
                        row_d   = '0;
                    end else if (last_row || !i_enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        row_d   = o_row + ROW_W'(1);
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        flush_d = (state_d == S_FLUSH);
        rd_d    = (state_d == S_BURST);
        // Tags follow the read issued this cycle; FIFO latency is one cycle.
        valid_d = (state_q == S_BURST);
        sol_d   = valid_d && (col_q == '0);
        eol_d   = valid_d && last_col && !abort;
        sof_d   = sol_d && (o_row == '0);
        eof_d   = eol_d && last_row;
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            fcnt_q      <= '0;
            o_row       <= '0;
            o_flush     <= 1'b0;
            o_rd        <= 1'b0;
            o_valid     <= 1'b0;
            o_sol       <= 1'b0;
            o_eol       <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            fcnt_q      <= fcnt_d;
            o_row       <= row_d;
            o_flush     <= flush_d;
            o_rd        <= rd_d;
            o_valid     <= valid_d;
            o_sol       <= sol_d;
            o_eol       <= eol_d;
            o_sof       <= sof_d;
            o_eof       <= eof_d;
            o_frame_err <= abort;
        end
    end

endmodule

// File: doc/pp_row_scheduler.md
Name: pp_row_scheduler

Overview:
- Frame/row sequencer for the preprocess output FIFO (greyscale/passthrough stage) feeding the Gaussian stage.
- Flushes the FIFO at each frame start, then waits until a full row is buffered and the downstream consumer is ready.
- Issues exactly one row of back-to-back FIFO reads and tags the returned pixels with start/end-of-line and start/end-of-frame markers.
- Detects frames that are truncated by an early frame start.

Parameters:
- ROW_WIDTH, 640: pixels per row (read burst length).
- NUM_ROWS, 480: rows per frame.
- FILL_W, 11: width of the FIFO fill-level input.
- FLUSH_CYCLES, 4: cycles `o_flush` is held high at frame start (1..15).

Ports:
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  asynchronous active-low reset.
- `i_enable`  in  1  scheduler enable (mode/run switch).
- `i_frame_start`  in  1  single-cycle pulse, camera vsync-derived.
- `i_fill`  in  FILL_W  preprocess FIFO fill level.
- `i_ds_ready`  in  1  downstream can accept one full row.
- `o_flush`  out  1  FIFO flush (ORed into FIFO reset by the parent).
- `o_rd`  out  1  FIFO read enable.
- `o_valid`  out  1  FIFO read data valid; FIFO read latency is 1.
- `o_sol`, `o_eol`  out  1  first / last pixel of a row, qualified by `o_valid`.
- `o_sof`, `o_eof`  out  1  first pixel of row 0 / last pixel of row NUM_ROWS-1, qualified by `o_valid`.
- `o_row`  out  clog2(NUM_ROWS)  index of the row currently being / last issued.
- `o_busy`  out  1  high in any state except IDLE.
- `o_frame_err`  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset:
  - Asynchronous, active-low.
  - All outputs go to 0, state goes to IDLE, column and row counters go to 0, the valid pipeline is cleared.
  - Reset mid-burst drops the burst immediately; no `o_eol` is emitted.
- States:
  - IDLE -> FLUSH on `i_enable && i_frame_start`.
  - FLUSH: `o_flush` = 1 for exactly FLUSH_CYCLES cycles; `o_row` cleared. Then -> WAIT.
  - WAIT -> BURST when `i_fill >= ROW_WIDTH && i_ds_ready`. If `i_fill` = ROW_WIDTH-1, stay in WAIT.
  - WAIT -> IDLE if `i_enable` = 0.
  - BURST:
    - `o_rd` = 1 for exactly ROW_WIDTH consecutive cycles, registered; first `o_rd` is the cycle after the WAIT decision.
    - Column counter 0..ROW_WIDTH-1.
    - `i_ds_ready` and `i_fill` are ignored once the burst has started.
  - End of burst:
    - If `o_row` = NUM_ROWS-1, frame is complete -> IDLE.
    - Else `o_row` increments -> WAIT.
    - If `i_enable` = 0 at end of burst -> IDLE (the burst always completes).
- Output pipeline:
  - `o_valid` = `o_rd` delayed 1 cycle.
  - `o_sol` / `o_eol` / `o_sof` / `o_eof` are registered alongside `o_valid` and derived from the column and row counters of the corresponding `o_rd` cycle.
  - For ROW_WIDTH = 1, `o_sol` and `o_eol` are asserted on the same cycle.
- Frame start while busy:
  - `i_frame_start` in FLUSH: restarts the flush count.
  - `i_frame_start` in WAIT or BURST (not the final `o_rd` of row NUM_ROWS-1):
    - Abort: `o_rd` drops the next cycle; no `o_eol`/`o_eof` is generated for the partial row.
    - `o_frame_err` pulses 1 cycle.
    - Goes to FLUSH; `o_row` clears.
  - `i_frame_start` coincident with the final `o_rd` of the frame: the frame completes normally (`o_eof` emitted), then FLUSH. No error.
- `i_frame_start` with `i_enable` = 0 in IDLE: ignored.
- Row counter wraps only through FLUSH, never by increment past NUM_ROWS-1.
- `o_busy` is combinational from state.

Test Plan:
- Params ROW_WIDTH=8, NUM_ROWS=4, FLUSH_CYCLES=2. Reset, enable, pulse `i_frame_start` -> `o_flush` high 2 cycles, `o_busy`=1, state WAIT, `o_row`=0.
- `i_fill`=7, `i_ds_ready`=1 for 20 cycles -> no `o_rd`; set `i_fill`=8 -> 8 consecutive `o_rd`, `o_valid` the same 8 cycles delayed by 1, `o_sol` on the 1st, `o_eol` on the 8th, `o_sof` on the 1st.
- `i_fill` held at 8 with `i_ds_ready` toggling -> each row starts only when `i_ds_ready`=1; 4 rows give 32 valids, `o_eof` on valid 32 only, then IDLE with `o_busy`=0.
- Frame start during the 5th `o_rd` of row 2 -> `o_rd` low next cycle, `o_frame_err`=1 for 1 cycle, no `o_eol`, 2-cycle flush, `o_row`=0.
- Frame start on the final `o_rd` of row 3 -> `o_eof` emitted, `o_frame_err`=0, new flush follows.
- Deassert `i_rstn` mid-burst (async, between clock edges) -> `o_rd`/`o_valid`/`o_flush` go to 0 immediately; after release, state IDLE with no spurious `o_eol`.
